// File: rtl/flash_read_ctrl.sv
// SPI flash reader: a key_flag pulse issues READ (0x03) at a fixed 24-bit address and
// streams NUM_BYTE bytes out on rx_data/rx_valid. SPI mode 0, sck = sys_clk/4.
module flash_read_ctrl #(
  parameter logic [7:0]  READ_CMD  = 8'h03,
  parameter logic [7:0]  S_ADDR    = 8'h00,
  parameter logic [7:0]  P_ADDR    = 8'h04,
  parameter logic [7:0]  B_ADDR    = 8'h25,
  parameter logic [15:0] NUM_BYTE  = 16'd100,
  parameter logic [5:0]  GUARD_CLK = 6'd32
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_flag,
  input  logic       miso,
  output logic       cs_n,
  output logic       sck,
  output logic       mosi,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    SETUP = 5'b00010,
    CMD   = 5'b00100,
    READ  = 5'b01000,
    HOLD  = 5'b10000
  } state_t;

  localparam logic [31:0] CMD_WORD   = {READ_CMD, S_ADDR, P_ADDR, B_ADDR};
  localparam logic [6:0]  GUARD_LAST = {1'b0, GUARD_CLK} - 7'd1;
  localparam logic [6:0]  GUARD_END  = {1'b0, GUARD_CLK};
  localparam logic [15:0] BYTE_LAST  = NUM_BYTE - 16'd1;

  state_t      state, nxt_state;
  logic [6:0]  cnt, nxt_cnt;
  logic [15:0] byte_cnt, nxt_byte_cnt;
  logic [7:0]  shreg;
  logic [4:0]  bit_idx;
  logic        cs_n_d, sck_d, mosi_d, done_d, sample, byte_end;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      byte_cnt <= '0;
    end else begin
      state    <= nxt_state;
      cnt      <= nxt_cnt;
      byte_cnt <= nxt_byte_cnt;
    end
  end

  // cnt is the cycle index within the current state; in CMD/READ its low two bits
  // are the bit-slot phase and the upper bits the bit number.
  always_comb begin
    nxt_state    = state;
    nxt_cnt      = cnt + 7'd1;
    nxt_byte_cnt = byte_cnt;
    case (state)
      IDLE: begin
        nxt_cnt = '0;
        if (key_flag) nxt_state = SETUP;
      end
      SETUP: if (cnt == GUARD_LAST) begin
        nxt_state = CMD;
        nxt_cnt   = '0;
      end
      CMD: if (cnt == 7'd127) begin
        nxt_state = READ;
        nxt_cnt   = '0;
      end
      READ: if (cnt == 7'd31) begin
        nxt_cnt = '0;
        if (byte_cnt == BYTE_LAST) begin
          nxt_state    = HOLD;
          nxt_byte_cnt = '0;
        end else begin
          nxt_byte_cnt = byte_cnt + 16'd1;
        end
      end
      HOLD: if (cnt == GUARD_END) begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
      end
      default: begin
        nxt_state    = IDLE;
        nxt_cnt      = '0;
        nxt_byte_cnt = '0;
      end
    endcase
  end

  // Pin values are decoded from the next state so every output leaves a flop;
  // the extra HOLD cycle at cnt == GUARD_CLK is the done cycle with cs_n released.
  always_comb begin
    bit_idx  = 5'd31 - nxt_cnt[6:2];
    done_d   = (nxt_state == HOLD) && (nxt_cnt == GUARD_END);
    cs_n_d   = (nxt_state == IDLE) || done_d;
    sck_d    = ((nxt_state == CMD) || (nxt_state == READ)) && nxt_cnt[1];
    mosi_d   = (nxt_state == CMD) && CMD_WORD[bit_idx];
    sample   = ((state == CMD) || (state == READ)) && (cnt[1:0] == 2'd2);
    byte_end = (state == READ) && (cnt == 7'd31);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cs_n     <= 1'b1;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      shreg    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      cs_n     <= cs_n_d;
      sck      <= sck_d;
      mosi     <= mosi_d;
      busy     <= ~cs_n_d;
      done     <= done_d;
      rx_valid <= byte_end;
      if (sample)   shreg   <= {shreg[6:0], miso};
      if (byte_end) rx_data <= shreg;
    end
  end

endmodule

// File: tb/tb_flash_read_ctrl.sv
// Bench for flash_read_ctrl: two DUTs (NUM_BYTE=1 and 4) against a bit-indexed flash
// model; transaction expectations come from byte counts and fixed guard/command lengths.
module tb_flash_read_ctrl;

  localparam int G = 32;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       key_flag [2];
  logic       miso     [2] = '{1'b0, 1'b0};
  logic       cs_n     [2];
  logic       sck      [2];
  logic       mosi     [2];
  logic [7:0] rx_data  [2];
  logic       rx_valid [2];
  logic       busy     [2];
  logic       done     [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0]  fdata [2][8];
  int          rises [2], tot_rises [2], cs_low [2], rxn [2], done_n [2], done_t [2];
  int          coinc [2], busy_bad [2], mosi_bad [2], clr_gen [2], seen_gen [2];
  logic [31:0] cmd_w [2];
  logic [7:0]  rxd   [2][16];
  int          rxt   [2][16];
  logic        psck  [2] = '{1'b0, 1'b0};
  int          rel;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  flash_read_ctrl #(.NUM_BYTE(16'd1)) dut_one (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_flag(key_flag[0]), .miso(miso[0]),
    .cs_n(cs_n[0]), .sck(sck[0]), .mosi(mosi[0]), .rx_data(rx_data[0]),
    .rx_valid(rx_valid[0]), .busy(busy[0]), .done(done[0]));

  flash_read_ctrl #(.NUM_BYTE(16'd4)) dut_four (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_flag(key_flag[1]), .miso(miso[1]),
    .cs_n(cs_n[1]), .sck(sck[1]), .mosi(mosi[1]), .rx_data(rx_data[1]),
    .rx_valid(rx_valid[1]), .busy(busy[1]), .done(done[1]));

  // Flash model and pin monitor: bit n after cs_n falls is the n-th sck rise;
  // bits >= 32 are data, driven while sck is low.
  always @(negedge sys_clk) begin
    for (int k = 0; k < 2; k++) begin
      if (clr_gen[k] != seen_gen[k]) begin
        seen_gen[k] = clr_gen[k];
        cs_low[k] = 0; tot_rises[k] = 0; rxn[k] = 0; done_n[k] = 0;
        coinc[k] = 0; busy_bad[k] = 0; mosi_bad[k] = 0; cmd_w[k] = '0;
      end
      if (cs_n[k]) rises[k] = 0; else cs_low[k]++;
      if (busy[k] !== ~cs_n[k]) busy_bad[k]++;
      if (sck[k] && !psck[k]) begin
        if (rises[k] < 32) cmd_w[k] = {cmd_w[k][30:0], mosi[k]};
        else if (mosi[k] !== 1'b0) mosi_bad[k]++;
        rises[k]++;
        tot_rises[k]++;
      end
      if (!cs_n[k] && !sck[k]) begin
        if (rises[k] >= 32 && rises[k] < 32 + 64) begin
          rel = rises[k] - 32;
          miso[k] = fdata[k][rel / 8][7 - (rel % 8)];
        end else begin
          miso[k] = 1'($urandom);
        end
      end
      if (rx_valid[k]) begin
        if (rxn[k] < 16) begin
          rxd[k][rxn[k]] = rx_data[k];
          rxt[k][rxn[k]] = cyc;
        end
        rxn[k]++;
      end
      if (done[k]) begin
        done_n[k]++;
        done_t[k] = cyc;
        if (rx_valid[k]) coinc[k]++;
      end
      psck[k] = sck[k];
    end
  end

  task automatic tick;
    @(negedge sys_clk);
    #1;
  endtask

  task automatic clr(input int k);
    clr_gen[k]++;
  endtask

  task automatic start_and_wait(input int k, input int x1, input int x2, output bit to);
    to = 1'b1;
    clr(k);
    tick; key_flag[k] = 1'b1;
    tick; key_flag[k] = 1'b0;
    for (int n = 1; n < 5000; n++) begin
      tick;
      if (done_n[k] > 0) begin
        to = 1'b0;
        break;
      end
      key_flag[k] = (n == x1) || (n == x2);
    end
    key_flag[k] = 1'b0;
  endtask

  task automatic test_reset;
    int rb [2];
    rb = '{0, 0};
    sys_rst_n = 1'b0;
    key_flag[0] = 1'b0;
    key_flag[1] = 1'b0;
    repeat (5) tick;
    sys_rst_n = 1'b1;
    repeat (500) begin
      tick;
      for (int k = 0; k < 2; k++)
        if ({cs_n[k], sck[k], mosi[k], rx_valid[k], busy[k], done[k]} !== 6'b100000 ||
            rx_data[k] !== 8'h00) rb[k]++;
    end
    for (int k = 0; k < 2; k++) begin
      total++;
      if (rb[k] !== 0) begin
        bad++;
        $display("FAIL reset_idle dut%0d bad_cycles=%0d want=0", k, rb[k]);
      end
      total++;
      if (done_n[k] !== 0) begin
        bad++;
        $display("FAIL reset_no_done dut%0d got=%0d want=0", k, done_n[k]);
      end
    end
  endtask

  task automatic test_single;
    bit to;
    fdata[0][0] = 8'hA5;
    start_and_wait(0, 0, 0, to);
    total++;
    if (to !== 1'b0) begin bad++; $display("FAIL single_timeout got=%0b want=0", to); end
    total++;
    if ({done[0], cs_n[0], busy[0]} !== 3'b110) begin
      bad++; $display("FAIL single_done_cycle got=%b want=110", {done[0], cs_n[0], busy[0]});
    end
    repeat (5) tick;
    total++;
    if (cmd_w[0] !== 32'h03000425) begin
      bad++; $display("FAIL single_cmd got=%h want=03000425", cmd_w[0]);
    end
    total++;
    if (rxn[0] !== 1) begin bad++; $display("FAIL single_rx_count got=%0d want=1", rxn[0]); end
    total++;
    if (rxd[0][0] !== 8'hA5) begin bad++; $display("FAIL single_rx_data got=%h want=a5", rxd[0][0]); end
    total++;
    if (cs_low[0] !== 2 * G + 128 + 32) begin
      bad++; $display("FAIL single_cs_low got=%0d want=%0d", cs_low[0], 2 * G + 160);
    end
    total++;
    if (tot_rises[0] !== 40) begin bad++; $display("FAIL single_sck_rises got=%0d want=40", tot_rises[0]); end
    total++;
    if (done_n[0] !== 1) begin bad++; $display("FAIL single_done_count got=%0d want=1", done_n[0]); end
    total++;
    if (busy_bad[0] + mosi_bad[0] !== 0) begin
      bad++; $display("FAIL single_busy_mosi got=%0d/%0d want=0/0", busy_bad[0], mosi_bad[0]);
    end
  endtask

  task automatic test_multi;
    bit to;
    logic [7:0] e [4];
    e = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) fdata[1][i] = e[i];
    start_and_wait(1, 0, 0, to);
    repeat (5) tick;
    total++;
    if (to !== 1'b0 || rxn[1] !== 4) begin
      bad++; $display("FAIL multi_count timeout=%0b got=%0d want=4", to, rxn[1]);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rxd[1][i] !== e[i]) begin bad++; $display("FAIL multi_data[%0d] got=%h want=%h", i, rxd[1][i], e[i]); end
      if (i > 0) begin
        total++;
        if (rxt[1][i] - rxt[1][i-1] !== 32) begin
          bad++; $display("FAIL multi_spacing[%0d] got=%0d want=32", i, rxt[1][i] - rxt[1][i-1]);
        end
      end
    end
    total++;
    if (tot_rises[1] !== 64) begin bad++; $display("FAIL multi_sck_rises got=%0d want=64", tot_rises[1]); end
    total++;
    if (cs_low[1] !== 2 * G + 128 + 128) begin
      bad++; $display("FAIL multi_cs_low got=%0d want=%0d", cs_low[1], 2 * G + 256);
    end
    total++;
    if (coinc[1] !== 0 || (done_t[1] > rxt[1][3]) !== 1'b1) begin
      bad++; $display("FAIL multi_done_after_rx coinc=%0d done_t=%0d last_rx=%0d", coinc[1], done_t[1], rxt[1][3]);
    end
  endtask

  task automatic test_random;
    bit to;
    logic [7:0] e [4];
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        e[i] = 8'($urandom);
        fdata[1][i] = e[i];
      end
      start_and_wait(1, 0, 0, to);
      total++;
      if (to !== 1'b0 || rxn[1] !== 4 || cs_low[1] !== 2 * G + 256) begin
        bad++; $display("FAIL random_txn[%0d] timeout=%0b rx=%0d cs_low=%0d want=4/%0d", r, to, rxn[1], cs_low[1], 2 * G + 256);
      end
      for (int i = 0; i < 4; i++) begin
        total++;
        if (rxd[1][i] !== e[i]) begin bad++; $display("FAIL random_data[%0d][%0d] got=%h want=%h", r, i, rxd[1][i], e[i]); end
      end
    end
  endtask

  task automatic test_ignore_busy;
    bit to;
    logic [7:0] e [4];
    for (int i = 0; i < 4; i++) begin
      e[i] = 8'($urandom);
      fdata[1][i] = e[i];
    end
    start_and_wait(1, 80, 200, to);
    repeat (10) tick;
    total++;
    if (to !== 1'b0 || cs_low[1] !== 2 * G + 256) begin
      bad++; $display("FAIL ignore_len timeout=%0b got=%0d want=%0d", to, cs_low[1], 2 * G + 256);
    end
    total++;
    if (done_n[1] !== 1 || cs_n[1] !== 1'b1) begin
      bad++; $display("FAIL ignore_done got=%0d cs_n=%b want=1/1", done_n[1], cs_n[1]);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rxd[1][i] !== e[i]) begin bad++; $display("FAIL ignore_data[%0d] got=%h want=%h", i, rxd[1][i], e[i]); end
    end
  endtask

  task automatic test_reset_mid;
    bit to;
    int w;
    logic [7:0] e [4];
    for (int i = 0; i < 4; i++) begin
      e[i] = 8'($urandom);
      fdata[1][i] = e[i];
    end
    clr(1);
    tick; key_flag[1] = 1'b1;
    tick; key_flag[1] = 1'b0;
    w = 0;
    while (rxn[1] < 1 && w < 1000) begin tick; w++; end
    total++;
    if (rxn[1] !== 1) begin bad++; $display("FAIL rmid_first_byte got=%0d want=1", rxn[1]); end
    repeat (10) tick;
    sys_rst_n = 1'b0;
    #1;
    total++;
    if ({cs_n[1], sck[1], rx_valid[1], busy[1], done[1]} !== 5'b10000 || rx_data[1] !== 8'h00) begin
      bad++; $display("FAIL rmid_abort got=%b/%h want=10000/00",
                      {cs_n[1], sck[1], rx_valid[1], busy[1], done[1]}, rx_data[1]);
    end
    repeat (3) tick;
    sys_rst_n = 1'b1;
    repeat (3) tick;
    total++;
    if (done_n[1] !== 0) begin bad++; $display("FAIL rmid_no_done got=%0d want=0", done_n[1]); end
    start_and_wait(1, 0, 0, to);
    total++;
    if (to !== 1'b0 || rxn[1] !== 4 || cs_low[1] !== 2 * G + 256) begin
      bad++; $display("FAIL rmid_restart timeout=%0b rx=%0d cs_low=%0d", to, rxn[1], cs_low[1]);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rxd[1][i] !== e[i]) begin bad++; $display("FAIL rmid_data[%0d] got=%h want=%h", i, rxd[1][i], e[i]); end
    end
  endtask

  task automatic test_back_to_back;
    bit to;
    int w;
    start_and_wait(1, 0, 0, to);
    total++;
    if (to !== 1'b0) begin bad++; $display("FAIL b2b_first timeout=%0b want=0", to); end
    key_flag[1] = 1'b1;
    tick; key_flag[1] = 1'b0;
    total++;
    if (cs_n[1] !== 1'b1) begin bad++; $display("FAIL b2b_coinc_d1 cs_n=%b want=1", cs_n[1]); end
    tick;
    total++;
    if ({cs_n[1], busy[1]} !== 2'b10) begin
      bad++; $display("FAIL b2b_coinc_d2 got=%b want=10", {cs_n[1], busy[1]});
    end
    start_and_wait(1, 0, 0, to);
    total++;
    if (to !== 1'b0) begin bad++; $display("FAIL b2b_second timeout=%0b want=0", to); end
    clr(1);
    tick; key_flag[1] = 1'b1;
    total++;
    if (cs_n[1] !== 1'b1) begin bad++; $display("FAIL b2b_next_d1 cs_n=%b want=1", cs_n[1]); end
    tick; key_flag[1] = 1'b0;
    total++;
    if ({cs_n[1], busy[1]} !== 2'b01) begin
      bad++; $display("FAIL b2b_next_d2 got=%b want=01", {cs_n[1], busy[1]});
    end
    w = 0;
    while (done_n[1] == 0 && w < 1000) begin tick; w++; end
    total++;
    if (done_n[1] !== 1 || rxn[1] !== 4 || cs_low[1] !== 2 * G + 256) begin
      bad++; $display("FAIL b2b_next_txn done=%0d rx=%0d cs_low=%0d want=1/4/%0d", done_n[1], rxn[1], cs_low[1], 2 * G + 256);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_multi;
    test_random;
    test_ignore_busy;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
